// File: rtl/med_blocos_ctrl.sv
// med_blocos_ctrl: sequencing controller for the block-average downscaler.
//
// On a start request it walks a LARGURA x ALTURA 8-bit frame, held in a
// synchronous-read RAM, in FATOR x FATOR blocks. It accumulates each block
// and writes the truncated mean to the NEW_LARG x NEW_ALTURA output RAM.
// It owns both memory ports for the whole frame.
//
// Ports:
//   clk      in   clock, all state on rising edge
//   rst_n    in   asynchronous active-low reset
//   iniciar  in   start request, sampled only in OCIOSO
//   ocupado  out  high whenever the FSM is not in OCIOSO
//   pronto   out  one-cycle pulse, frame complete
//   rd_en    out  input RAM read strobe
//   rd_addr  out  input RAM address (0 when rd_en=0)
//   rd_data  in   input RAM data, valid one cycle after rd_en
//   wr_en    out  output RAM write strobe
//   wr_addr  out  output pixel index (0 when wr_en=0)
//   wr_data  out  block mean (0 when wr_en=0)
//
// Handshake: there is no backpressure. A read issued with rd_en in cycle N
// returns rd_data in cycle N+1; a write is taken by the RAM in every cycle
// wr_en is high. All strobes and the status outputs come straight from
// flops, so no input reaches an output combinationally.
// The FSM state is held in the signal 'state' for hierarchical probing.

module med_blocos_ctrl #(
  parameter int LARGURA    = 80,
  parameter int ALTURA     = 60,
  parameter int FATOR      = 2,
  parameter int NEW_LARG   = LARGURA / FATOR,
  parameter int NEW_ALTURA = ALTURA / FATOR,
  parameter int ADDR_W     = 13,
  parameter int OUT_ADDR_W = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iniciar,
  output logic                  ocupado,
  output logic                  pronto,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [7:0]            rd_data,
  output logic                  wr_en,
  output logic [OUT_ADDR_W-1:0] wr_addr,
  output logic [7:0]            wr_data
);

  localparam int LOG_F  = $clog2(FATOR);
  localparam int SH     = 2 * LOG_F;
  localparam int SOMA_W = 8 + SH;
  localparam int DW     = (LOG_F > 0) ? LOG_F : 1;

  localparam logic [DW-1:0]     D_LAST   = DW'(FATOR - 1);
  localparam logic [ADDR_W-1:0] LIN_LAST = ADDR_W'(ALTURA - FATOR);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(LARGURA - FATOR);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(FATOR);

  // Reject illegal geometry at elaboration time.
  if (!(FATOR == 1 || FATOR == 2 || FATOR == 4 || FATOR == 8) ||
      (LARGURA % FATOR) != 0 || (ALTURA % FATOR) != 0 ||
      (2 ** ADDR_W) < LARGURA * ALTURA ||
      (2 ** OUT_ADDR_W) < NEW_LARG * NEW_ALTURA) begin : g_bad_param
    $error("med_blocos_ctrl: illegal parameter combination");
  end

  typedef enum logic [2:0] {OCIOSO, LER, ACUM, ESCREVER, FIM} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   linha;     // block anchor row, in pixels
  logic [ADDR_W-1:0]   coluna;    // block anchor column, in pixels
  logic [DW-1:0]       di;
  logic [DW-1:0]       dj;
  logic [SOMA_W-1:0]   soma;
  logic                rd_en_d;   // qualifies rd_data this cycle

  logic [DW-1:0]       di_nx;
  logic [DW-1:0]       dj_nx;
  logic [ADDR_W-1:0]   linha_nx;
  logic [ADDR_W-1:0]   coluna_nx;
  logic [SOMA_W-1:0]   soma_nx;
  logic                ultimo_px;
  logic                ultimo_blk;

  function automatic logic [ADDR_W-1:0] in_addr(
    input logic [ADDR_W-1:0] l,
    input logic [ADDR_W-1:0] c,
    input logic [DW-1:0]     i,
    input logic [DW-1:0]     j
  );
    return (l + ADDR_W'(i)) * ADDR_W'(LARGURA) + c + ADDR_W'(j);
  endfunction

  function automatic logic [OUT_ADDR_W-1:0] out_addr(
    input logic [ADDR_W-1:0] l,
    input logic [ADDR_W-1:0] c
  );
    return OUT_ADDR_W'((l >> LOG_F) * ADDR_W'(NEW_LARG) + (c >> LOG_F));
  endfunction

  always_comb begin
    ultimo_px  = (di == D_LAST) && (dj == D_LAST);
    ultimo_blk = (linha == LIN_LAST) && (coluna == COL_LAST);
    // di outer, dj inner
    if (dj == D_LAST) begin
      dj_nx = '0;
      di_nx = di + DW'(1);
    end else begin
      dj_nx = dj + DW'(1);
      di_nx = di;
    end
    if (coluna == COL_LAST) begin
      coluna_nx = '0;
      linha_nx  = linha + STEP;
    end else begin
      coluna_nx = coluna + STEP;
      linha_nx  = linha;
    end
    soma_nx = rd_en_d ? (soma + SOMA_W'(rd_data)) : soma;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= OCIOSO;
      linha   <= '0;
      coluna  <= '0;
      di      <= '0;
      dj      <= '0;
      soma    <= '0;
      rd_en_d <= 1'b0;
      ocupado <= 1'b0;
      pronto  <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      rd_en_d <= rd_en;
      soma    <= soma_nx;
      case (state)
        OCIOSO: begin
          if (iniciar) begin
            state   <= LER;
            ocupado <= 1'b1;
            linha   <= '0;
            coluna  <= '0;
            di      <= '0;
            dj      <= '0;
            soma    <= '0;
            rd_en   <= 1'b1;
            rd_addr <= '0;
          end
        end
        LER: begin
          if (ultimo_px) begin
            state   <= ACUM;
            rd_en   <= 1'b0;
            rd_addr <= '0;
          end else begin
            di      <= di_nx;
            dj      <= dj_nx;
            rd_addr <= in_addr(linha, coluna, di_nx, dj_nx);
          end
        end
        ACUM: begin
          // The last pixel is added this cycle, so the mean is taken from
          // soma_nx rather than the not-yet-updated soma.
          state   <= ESCREVER;
          di      <= '0;
          dj      <= '0;
          wr_en   <= 1'b1;
          wr_addr <= out_addr(linha, coluna);
          wr_data <= 8'(soma_nx >> SH);
        end
        ESCREVER: begin
          wr_en   <= 1'b0;
          wr_addr <= '0;
          wr_data <= '0;
          soma    <= '0;
          if (ultimo_blk) begin
            state  <= FIM;
            pronto <= 1'b1;
          end else begin
            state   <= LER;
            linha   <= linha_nx;
            coluna  <= coluna_nx;
            rd_en   <= 1'b1;
            rd_addr <= in_addr(linha_nx, coluna_nx, '0, '0);
          end
        end
        FIM: begin
          state   <= OCIOSO;
          pronto  <= 1'b0;
          ocupado <= 1'b0;
        end
        default: begin
          state   <= OCIOSO;
          ocupado <= 1'b0;
          pronto  <= 1'b0;
          rd_en   <= 1'b0;
          rd_addr <= '0;
          wr_en   <= 1'b0;
          wr_addr <= '0;
          wr_data <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_med_blocos_ctrl.sv
// Testbench for med_blocos_ctrl: a 4x4 FATOR=2 instance (dut_a) and a
// 2x2 FATOR=1 instance (dut_b) sharing clock and reset, each with its own
// synchronous-read input RAM model.

module tb_med_blocos_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         checks = 0;
  int         failures = 0;

  // dut_a: 4x4, FATOR=2
  logic       iniciar_a = 1'b0;
  logic       ocupado_a, pronto_a, rd_en_a, wr_en_a;
  logic [3:0] rd_addr_a;
  logic [7:0] rd_data_a = '0;
  logic [1:0] wr_addr_a;
  logic [7:0] wr_data_a;
  logic [7:0] mem_a [16];

  // dut_b: 2x2, FATOR=1
  logic       iniciar_b = 1'b0;
  logic       ocupado_b, pronto_b, rd_en_b, wr_en_b;
  logic [1:0] rd_addr_b;
  logic [7:0] rd_data_b = '0;
  logic [1:0] wr_addr_b;
  logic [7:0] wr_data_b;
  logic [7:0] mem_b [4];

  // per-frame observations of dut_a
  int         rd_cyc_q[$];
  logic [3:0] rd_addr_q[$];
  int         wr_cyc_q[$];
  logic [1:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  int         pronto_n, pronto_cyc, both_err, zero_err;
  logic       ocup_after;

  always #5 clk = ~clk;

  med_blocos_ctrl #(.LARGURA(4), .ALTURA(4), .FATOR(2), .ADDR_W(4), .OUT_ADDR_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .iniciar(iniciar_a), .ocupado(ocupado_a), .pronto(pronto_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a));

  med_blocos_ctrl #(.LARGURA(2), .ALTURA(2), .FATOR(1), .ADDR_W(2), .OUT_ADDR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .iniciar(iniciar_b), .ocupado(ocupado_b), .pronto(pronto_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b));

  always @(posedge clk) if (rd_en_a) rd_data_a <= mem_a[rd_addr_a];
  always @(posedge clk) if (rd_en_b) rd_data_b <= mem_b[rd_addr_b];

  task automatic load_ramp();
    for (int i = 0; i < 16; i++) mem_a[i] = 8'(i);
  endtask

  // Start dut_a and record one frame. Cycle 1 is the cycle after the edge
  // that samples iniciar. pulse_at>0 re-pulses iniciar in that cycle.
  task automatic run_frame_a(input int pulse_at);
    rd_cyc_q.delete(); rd_addr_q.delete();
    wr_cyc_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    pronto_n = 0; pronto_cyc = 0; both_err = 0; zero_err = 0; ocup_after = 1'bx;
    iniciar_a = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 60; k++) begin
      iniciar_a = (k == pulse_at);
      if (rd_en_a) begin rd_cyc_q.push_back(k); rd_addr_q.push_back(rd_addr_a); end
      if (wr_en_a) begin
        wr_cyc_q.push_back(k); wr_addr_q.push_back(wr_addr_a); wr_data_q.push_back(wr_data_a);
      end
      if (rd_en_a && wr_en_a) both_err++;
      if ((!rd_en_a && rd_addr_a != 0) || (!wr_en_a && (wr_addr_a != 0 || wr_data_a != 0))) zero_err++;
      if (pronto_a) begin pronto_n++; pronto_cyc = k; end
      if (pronto_cyc != 0 && k == pronto_cyc + 1) begin ocup_after = ocupado_a; break; end
      @(posedge clk); #1;
    end
    iniciar_a = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ocupado_a, pronto_a, rd_en_a, wr_en_a, rd_addr_a, wr_addr_a, wr_data_a} !== '0) begin
      failures++;
      $display("FAIL reset_a: got oc=%b pr=%b rd=%b wr=%b ra=%0d wa=%0d wd=%0d, want all 0",
               ocupado_a, pronto_a, rd_en_a, wr_en_a, rd_addr_a, wr_addr_a, wr_data_a);
    end
    checks++;
    if ({ocupado_b, pronto_b, rd_en_b, wr_en_b, rd_addr_b, wr_addr_b, wr_data_b} !== '0) begin
      failures++;
      $display("FAIL reset_b: got oc=%b pr=%b rd=%b wr=%b, want all 0",
               ocupado_b, pronto_b, rd_en_b, wr_en_b);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Compares the recorded writes against the ramp frame means.
  task automatic check_ramp_writes(input string tag);
    logic [7:0] exp_d [4] = '{8'd2, 8'd4, 8'd10, 8'd12};
    checks++;
    if (wr_addr_q.size() !== 4) begin
      failures++;
      $display("FAIL %s_wr_count: got %0d want 4", tag, wr_addr_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_addr_q[i] !== 2'(i) || wr_data_q[i] !== exp_d[i]) begin
          failures++;
          $display("FAIL %s_wr%0d: got (%0d,%0d) want (%0d,%0d)",
                   tag, i, wr_addr_q[i], wr_data_q[i], i, exp_d[i]);
        end
      end
    end
    checks++;
    if (pronto_n !== 1 || pronto_cyc !== 25) begin
      failures++;
      $display("FAIL %s_pronto: got count=%0d cycle=%0d want count=1 cycle=25", tag, pronto_n, pronto_cyc);
    end
  endtask

  task automatic test_frame_basic();
    load_ramp();
    run_frame_a(0);
    check_ramp_writes("basic");
    checks++;
    if (wr_cyc_q.size() !== 4 || wr_cyc_q[0] !== 6 || wr_cyc_q[1] !== 12 ||
        wr_cyc_q[2] !== 18 || wr_cyc_q[3] !== 24) begin
      failures++;
      $display("FAIL basic_wr_cycles: got n=%0d first=%0d want 6,12,18,24",
               wr_cyc_q.size(), (wr_cyc_q.size() > 0) ? wr_cyc_q[0] : -1);
    end
    checks++;
    if (ocup_after !== 1'b0) begin
      failures++;
      $display("FAIL basic_ocupado_after: got %b want 0", ocup_after);
    end
    checks++;
    if (both_err !== 0 || zero_err !== 0) begin
      failures++;
      $display("FAIL basic_strobes: rd&wr=%0d nonzero_idle=%0d want 0,0", both_err, zero_err);
    end
  endtask

  task automatic test_block_reads();
    logic [3:0] exp_a [4] = '{4'd2, 4'd3, 4'd6, 4'd7};
    load_ramp();
    run_frame_a(0);
    checks++;
    if (rd_addr_q.size() !== 16) begin
      failures++;
      $display("FAIL reads_count: got %0d want 16", rd_addr_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rd_addr_q[4+i] !== exp_a[i] || rd_cyc_q[4+i] !== 7 + i) begin
          failures++;
          $display("FAIL reads_blk1_%0d: got addr=%0d cyc=%0d want addr=%0d cyc=%0d",
                   i, rd_addr_q[4+i], rd_cyc_q[4+i], exp_a[i], 7 + i);
        end
      end
      // cycle 11 is idle (next read is block 2 at 13), write at 12
      checks++;
      if (rd_cyc_q[8] !== 13 || wr_cyc_q.size() < 2 || wr_cyc_q[1] !== 12) begin
        failures++;
        $display("FAIL reads_idle_then_write: got next_rd=%0d want 13 with write at 12", rd_cyc_q[8]);
      end
    end
  endtask

  task automatic test_trunc();
    logic [7:0] init [16] = '{8'd1, 8'd1, 8'hFF, 8'hFF, 8'd1, 8'd2, 8'hFF, 8'hFF,
                              8'd0, 8'd0, 8'd3, 8'd4, 8'd0, 8'd0, 8'd5, 8'd6};
    logic [7:0] exp_d [4] = '{8'd1, 8'hFF, 8'd0, 8'd4};
    for (int i = 0; i < 16; i++) mem_a[i] = init[i];
    run_frame_a(0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_data_q.size() <= i || wr_data_q[i] !== exp_d[i]) begin
        failures++;
        $display("FAIL trunc_blk%0d: got %0d want %0d", i,
                 (wr_data_q.size() > i) ? int'(wr_data_q[i]) : -1, exp_d[i]);
      end
    end
  endtask

  task automatic test_ignore_restart();
    load_ramp();
    run_frame_a(10);
    check_ramp_writes("restart");
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ocupado_a !== 1'b0) begin
      failures++;
      $display("FAIL restart_no_queue: ocupado got %b want 0", ocupado_a);
    end
  endtask

  task automatic test_reset_mid();
    int wr_seen = 0;
    int pr_seen = 0;
    load_ramp();
    iniciar_a = 1'b1;
    @(posedge clk); #1;
    iniciar_a = 1'b0;
    for (int k = 1; k < 8; k++) begin
      if (wr_en_a && wr_addr_a != 0) wr_seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (rd_en_a !== 1'b1 || rd_addr_a !== 4'd3) begin
      failures++;
      $display("FAIL rstmid_pre: got rd_en=%b addr=%0d want 1,3", rd_en_a, rd_addr_a);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rd_en_a !== 1'b0 || wr_en_a !== 1'b0 || ocupado_a !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_async: got rd=%b wr=%b oc=%b want 0,0,0", rd_en_a, wr_en_a, ocupado_a);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (wr_en_a) wr_seen++;
      if (pronto_a) pr_seen++;
    end
    checks++;
    if (wr_seen !== 0 || pr_seen !== 0) begin
      failures++;
      $display("FAIL rstmid_quiet: got writes=%0d pronto=%0d want 0,0", wr_seen, pr_seen);
    end
    run_frame_a(0);
    check_ramp_writes("rstmid_rerun");
  endtask

  task automatic test_fator1();
    int n_wr = 0;
    int pr_cyc = 0;
    mem_b[0] = 8'h10; mem_b[1] = 8'h20; mem_b[2] = 8'h30; mem_b[3] = 8'h40;
    iniciar_b = 1'b1;
    @(posedge clk); #1;
    iniciar_b = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (wr_en_b) begin
        checks++;
        if (n_wr > 3 || wr_addr_b !== 2'(n_wr) || wr_data_b !== mem_b[n_wr] || k !== 3 * (n_wr + 1)) begin
          failures++;
          $display("FAIL f1_wr%0d: got (%0d,%0h) at cycle %0d want (%0d,%0h) at cycle %0d",
                   n_wr, wr_addr_b, wr_data_b, k, n_wr, mem_b[n_wr & 3], 3 * (n_wr + 1));
        end
        n_wr++;
      end
      if (pronto_b && pr_cyc == 0) pr_cyc = k;
      @(posedge clk); #1;
    end
    checks++;
    if (n_wr !== 4 || pr_cyc !== 13) begin
      failures++;
      $display("FAIL f1_frame: got writes=%0d pronto_cycle=%0d want 4,13", n_wr, pr_cyc);
    end
  endtask

  // iniciar held high through FIM: next frame's first read in cycle 15.
  task automatic test_back_to_back();
    int first2 = 0;
    logic was_low = 1'b0;
    iniciar_b = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 20; k++) begin
      if (k >= 13 && !rd_en_b) was_low = 1'b1;
      if (was_low && rd_en_b && first2 == 0) first2 = k;
      @(posedge clk); #1;
    end
    iniciar_b = 1'b0;
    checks++;
    if (first2 !== 15) begin
      failures++;
      $display("FAIL b2b_restart: got first read of frame 2 at cycle %0d want 15", first2);
    end
    for (int k = 0; k < 40 && ocupado_b; k++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (ocupado_b !== 1'b0) begin
      failures++;
      $display("FAIL b2b_finish: ocupado got %b want 0", ocupado_b);
    end
  endtask

  initial begin
    test_reset();
    test_frame_basic();
    test_block_reads();
    test_trunc();
    test_ignore_restart();
    test_reset_mid();
    test_fator1();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/med_blocos_ctrl.md
Name: med_blocos_ctrl

Overview:
Sequencing controller for the block-average downscaler. On a start pulse it walks an LARGURA×ALTURA 8-bit frame held in a synchronous-read RAM in FATOR×FATOR blocks. It accumulates each block and writes the truncated mean to the NEW_LARG×NEW_ALTURA output RAM. It sits between the frame buffer and the downscaled buffer and owns both memory ports for the duration of a frame.

Parameters:
LARGURA, 80, input frame width in pixels
ALTURA, 60, input frame height in pixels
FATOR, 2, block edge; legal values 1, 2, 4, 8; LARGURA and ALTURA must be multiples of FATOR, otherwise elaboration fails
NEW_LARG, LARGURA/FATOR, output width
NEW_ALTURA, ALTURA/FATOR, output height
ADDR_W, 13, input address width, must satisfy 2^ADDR_W >= LARGURA*ALTURA
OUT_ADDR_W, 11, output address width, must satisfy 2^OUT_ADDR_W >= NEW_LARG*NEW_ALTURA

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
iniciar  in  1  start request, sampled only in OCIOSO
ocupado  out  1  high whenever the FSM is not in OCIOSO
pronto  out  1  one-cycle pulse, frame complete
rd_en  out  1  input RAM read strobe
rd_addr  out  ADDR_W  input RAM address, valid when rd_en=1
rd_data  in  8  input RAM data, valid exactly one cycle after rd_en
wr_en  out  1  output RAM write strobe
wr_addr  out  OUT_ADDR_W  output pixel index, valid when wr_en=1
wr_data  out  8  block mean, valid when wr_en=1

Behaviour:
- Reset (async, rst_n=0): state OCIOSO. Block row/col, di/dj and soma are cleared. ocupado, pronto, rd_en and wr_en are 0. rd_addr, wr_addr and wr_data are 0.
- States: OCIOSO, LER, ACUM, ESCREVER, FIM.
- OCIOSO: if iniciar=1 at an edge, go to LER with block (0,0), di=dj=0 and soma=0.
- LER: rd_en=1 every cycle for FATOR² consecutive cycles.
  - rd_addr = (linha+di)*LARGURA + coluna+dj, where linha and coluna are the block anchor in pixels.
  - Scan order is di outer, dj inner.
  - After the cycle with di=dj=FATOR-1, go to ACUM.
- Accumulation: a one-cycle delayed copy of rd_en qualifies rd_data. When it is set, soma <= soma + rd_data.
  - soma width is 8+2*log2(FATOR), so it never overflows.
  - The add for the final read happens in the ACUM cycle.
- ACUM: one cycle, rd_en=0. Go to ESCREVER.
- ESCREVER: one cycle with wr_en=1.
  - wr_addr = (linha/FATOR)*NEW_LARG + coluna/FATOR.
  - wr_data = soma >> (2*log2 FATOR), i.e. floor division, no rounding.
  - soma is cleared.
  - If this was the last block, go to FIM. Otherwise advance coluna by FATOR; on coluna wrap to 0, advance linha by FATOR. Then go to LER.
- FIM: pronto=1 for one cycle, then go to OCIOSO.
- Timing:
  - Per block: FATOR²+2 cycles.
  - First rd_en is in the cycle after iniciar is sampled.
  - pronto occurs NEW_LARG*NEW_ALTURA*(FATOR²+2)+1 cycles after that sampling edge.
- Outputs: rd_en, wr_en, ocupado and pronto are pure functions of registered state (no combinational path from inputs). rd_addr, wr_addr and wr_data are 0 when their strobe is 0.
- Start rules:
  - iniciar while ocupado=1 is ignored: no restart and no queued start.
  - iniciar held high through FIM starts a new frame from the OCIOSO cycle that follows.
- Reset mid-frame: strobes drop immediately (async), no further writes occur, and the partial output is left as is.
- Never rd_en and wr_en in the same cycle.
- FATOR=1: one read per block, wr_data equals rd_data (pass-through at 3 cycles per pixel).

Test Plan:
- LARGURA=ALTURA=4, FATOR=2, input RAM = 0..15, pulse iniciar -> writes (addr,data) = (0,2),(1,4),(2,10),(3,12) in that order; pronto exactly 25 cycles after the iniciar sampling edge; ocupado low the next cycle.
- Same config, monitor reads for block 1 -> rd_addr sequence 2,3,6,7 on consecutive cycles, followed by one idle cycle, then wr_en.
- Block contents 1,1,1,2 -> wr_data=1 (truncation); all 0xFF -> wr_data=0xFF (no overflow, soma=1020).
- iniciar pulsed again at cycle 10 of a run -> no change to the address/write sequence; a single pronto.
- rst_n low during the second block's LER -> rd_en=wr_en=ocupado=0 immediately, no write for block 1, no pronto; a later iniciar produces a full correct frame.
- FATOR=1, LARGURA=ALTURA=2, input 0x10,0x20,0x30,0x40 -> writes (0,0x10),(1,0x20),(2,0x30),(3,0x40); pronto after 13 cycles.
